// File: rtl/demux_rr_if.sv
// Handshake bundle between an upstream producer, the round-robin demux and its
// eight downstream channels.
interface demux_rr_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic [7:0]   ch_ready;
    logic [7:0]   out_valid;
    logic [W-1:0] out_data;
    logic [2:0]   sel;

    modport master (
        output in_valid, in_data, ch_ready,
        input  in_ready, out_valid, out_data, sel
    );

    modport slave (
        input  in_valid, in_data, ch_ready,
        output in_ready, out_valid, out_data, sel
    );
endinterface

// File: rtl/demux_rr_scheduler.sv
// One-word buffered demux that hands each accepted word to the next enabled
// channel in round-robin order.
//
// state | meaning
// IDLE  | buffer empty, waiting for an upstream word
// HOLD  | one word buffered, offered to channel sel until ch_ready[sel]
module demux_rr_scheduler #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       ch_mask,
    output logic [15:0]      xfer_cnt,
    demux_rr_if.slave        bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state;
    logic [2:0]   ptr;
    logic [2:0]   sel_q;
    logic [W-1:0] data_q;
    logic [7:0]   valid_q;
    logic [2:0]   next_sel;
    logic         found;
    logic [2:0]   idx;
    logic         eligible;
    logic         accept;
    logic         xfer;

    // First enabled channel at or after ptr, wrapping modulo 8.
    always_comb begin
        next_sel = ptr;
        found    = 1'b0;
        idx      = ptr;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && ch_mask[idx]) begin
                next_sel = idx;
                found    = 1'b1;
            end
        end
    end

    assign eligible     = en && (ch_mask != 8'h00);
    assign xfer         = (state == HOLD) && bus.ch_ready[sel_q];
    assign bus.in_ready = !rst && eligible && ((state == IDLE) || xfer);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            sel_q    <= 3'd0;
            data_q   <= '0;
            valid_q  <= 8'h00;
            xfer_cnt <= 16'h0000;
        end else begin
            if (xfer)
                xfer_cnt <= xfer_cnt + 16'h0001;
            if (accept) begin
                state   <= HOLD;
                data_q  <= bus.in_data;
                sel_q   <= next_sel;
                ptr     <= next_sel + 3'd1;
                valid_q <= 8'h01 << next_sel;
            end else if (xfer) begin
                state   <= IDLE;
                valid_q <= 8'h00;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.sel       = sel_q;
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Scoreboard bench for demux_rr_scheduler: a reference model predicts the channel
// of every accepted word and checks it when the channel takes it.
module tb_demux_rr_scheduler;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic [15:0] xfer_cnt;

    demux_rr_if #(.W(W)) bus ();

    demux_rr_scheduler #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ch_mask  (ch_mask),
        .xfer_cnt (xfer_cnt),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    // Reference model state and scoreboard of {sel, data}
    logic         m_hold = 1'b0;
    logic [2:0]   m_ptr = 3'd0;
    logic [2:0]   m_sel = 3'd0;
    logic [15:0]  m_cnt = 16'h0000;
    logic [2+W:0] sb[$];
    logic [2:0]   log_sel[$];
    logic [7:0]   log_ov[$];
    logic [W-1:0] log_dat[$];

    // Inputs change 1 time unit after posedge, so at negedge they are what the next edge sees.
    always @(negedge clk) begin
        logic         exp_rdy;
        logic         xf;
        logic [2:0]   ns;
        logic         fnd;
        logic [2+W:0] e;
        exp_rdy = !rst && en && (ch_mask != 8'h00) && (!m_hold || bus.ch_ready[m_sel]);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), m_hold ? 32'(8'h01 << m_sel) : 32'd0);
        chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
        if (rst) begin
            m_hold = 1'b0;
            m_ptr  = 3'd0;
            m_sel  = 3'd0;
            m_cnt  = 16'h0000;
            sb.delete();
        end else begin
            xf = m_hold && bus.ch_ready[m_sel];
            if (xf) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("deliver_sel", 32'(bus.sel), 32'(e[2+W:W]));
                    chk("deliver_data", 32'(bus.out_data), 32'(e[W-1:0]));
                end
                log_sel.push_back(bus.sel);
                log_ov.push_back(bus.out_valid);
                log_dat.push_back(bus.out_data);
                m_cnt = m_cnt + 16'h0001;
            end
            if (bus.in_valid && exp_rdy) begin
                ns  = m_ptr;
                fnd = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if (!fnd && ch_mask[3'(m_ptr + 3'(k))]) begin
                        ns  = 3'(m_ptr + 3'(k));
                        fnd = 1'b1;
                    end
                end
                sb.push_back({ns, bus.in_data});
                m_sel  = ns;
                m_ptr  = ns + 3'd1;
                m_hold = 1'b1;
            end else if (xf) begin
                m_hold = 1'b0;
            end
        end
    end

    task automatic clear_log();
        log_sel.delete();
        log_ov.delete();
        log_dat.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.ch_ready = 8'h00;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        tick(1);

        // Fill and drain at one word per cycle across all eight channels
        clear_log();
        ch_mask = 8'hFF; en = 1'b1; bus.ch_ready = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(8'h10 + i);
            tick(1);
        end
        bus.in_valid = 1'b0;
        tick(2);
        chk("fill_count", 32'(log_sel.size()), 32'd9);
        for (int i = 0; i < 9 && i < log_sel.size(); i++) begin
            chk("fill_sel", 32'(log_sel[i]), 32'(i % 8));
            chk("fill_ov", 32'(log_ov[i]), 32'(8'h01 << (i % 8)));
            chk("fill_data", 32'(log_dat[i]), 32'(8'h10 + i));
        end
        chk("fill_xfer_cnt", 32'(xfer_cnt), 32'd9);

        // Sparse mask: channels 2 and 5, then full mask shows ptr landed on 3
        do_reset();
        clear_log();
        ch_mask = 8'h24;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(8'hA0 + i);
            tick(1);
        end
        bus.in_valid = 1'b0;
        tick(2);
        ch_mask = 8'hFF;
        bus.in_valid = 1'b1; bus.in_data = 8'h5A;
        tick(1);
        bus.in_valid = 1'b0;
        tick(2);
        chk("sparse_count", 32'(log_sel.size()), 32'd4);
        if (log_sel.size() == 4) begin
            chk("sparse_sel0", 32'(log_sel[0]), 32'd2);
            chk("sparse_sel1", 32'(log_sel[1]), 32'd5);
            chk("sparse_sel2", 32'(log_sel[2]), 32'd2);
            chk("sparse_ov1", 32'(log_ov[1]), 32'h20);
            chk("sparse_ptr3", 32'(log_sel[3]), 32'd3);
        end

        // Backpressure on channel 3, with a second word waiting upstream
        do_reset();
        clear_log();
        ch_mask = 8'h08; bus.ch_ready = 8'hF7;
        bus.in_valid = 1'b1; bus.in_data = 8'hAB;
        tick(1);
        bus.in_data = 8'hCD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ov", 32'(bus.out_valid), 32'h08);
            chk("bp_data", 32'(bus.out_data), 32'hAB);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            tick(1);
        end
        chk("bp_no_xfer", 32'(xfer_cnt), 32'd0);
        bus.ch_ready = 8'h08;
        tick(1);
        chk("bp_xfer", 32'(xfer_cnt), 32'd1);
        bus.in_valid = 1'b0;
        tick(2);
        if (log_dat.size() >= 2) begin
            chk("bp_first", 32'(log_dat[0]), 32'hAB);
            chk("bp_second", 32'(log_dat[1]), 32'hCD);
        end else begin
            chk("bp_count", 32'(log_dat.size()), 32'd2);
        end

        // Mask cleared and enable dropped while holding a word for channel 1
        do_reset();
        clear_log();
        ch_mask = 8'h02; en = 1'b1; bus.ch_ready = 8'h00;
        bus.in_valid = 1'b1; bus.in_data = 8'h77;
        tick(1);
        ch_mask = 8'h00; en = 1'b0; bus.in_data = 8'h88;
        tick(3);
        bus.ch_ready = 8'hFF;
        tick(1);
        @(negedge clk);
        chk("dis_ov_idle", 32'(bus.out_valid), 32'd0);
        chk("dis_in_ready", 32'(bus.in_ready), 32'd0);
        chk("dis_count", 32'(log_sel.size()), 32'd1);
        if (log_sel.size() == 1) begin
            chk("dis_sel", 32'(log_sel[0]), 32'd1);
            chk("dis_data", 32'(log_dat[0]), 32'h77);
        end
        tick(1);
        bus.in_valid = 1'b0;

        // Reset while holding with ch_ready[sel] and in_valid both high
        do_reset();
        clear_log();
        ch_mask = 8'h30; en = 1'b1; bus.ch_ready = 8'h00;
        bus.in_valid = 1'b1; bus.in_data = 8'h31;
        tick(1);
        bus.ch_ready = 8'hFF; bus.in_data = 8'h32; rst = 1'b1;
        tick(1);
        rst = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
        tick(1);
        bus.in_valid = 1'b1; bus.in_data = 8'h33;
        tick(1);
        bus.in_valid = 1'b0;
        tick(2);
        chk("mid_rst_count", 32'(log_sel.size()), 32'd1);
        if (log_sel.size() == 1)
            chk("mid_rst_sel", 32'(log_sel[0]), 32'd4);

        // Counter wrap through 0xFFFF
        do_reset();
        clear_log();
        ch_mask = 8'hFF; en = 1'b1; bus.ch_ready = 8'hFF;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus.in_data = W'(i);
            tick(1);
        end
        bus.in_valid = 1'b0;
        tick(1);
        chk("wrap_ffff", 32'(xfer_cnt), 32'hFFFF);
        bus.in_valid = 1'b1; bus.in_data = 8'hEE;
        tick(1);
        bus.in_valid = 1'b0;
        tick(1);
        chk("wrap_zero", 32'(xfer_cnt), 32'h0000);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/demux_rr_scheduler.md
DEMUX_RR_SCHEDULER -- requirements
Module: demux_rr_scheduler

Interface
REQ-001 Parameter W, default 8: data word width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 en  input  1  scheduler enable; 0 blocks new acceptance only.
REQ-005 ch_mask  input  8  per-channel enable; bit i=1 makes channel i eligible.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_data  input  W  upstream word.
REQ-008 in_ready  output  1  scheduler can accept in_data this cycle.
REQ-009 ch_ready  input  8  per-channel downstream ready.
REQ-010 out_valid  output  8  one-hot valid; bit sel set while a word is held.
REQ-011 out_data  output  W  held word, common to all channels.
REQ-012 sel  output  3  channel index of the held word.
REQ-013 xfer_cnt  output  16  count of completed channel transfers.

Function
REQ-014 States SHALL be IDLE (buffer empty) and HOLD (one word buffered).
REQ-015 Round-robin pointer ptr (3 bits) SHALL name the first channel searched at the next capture.
REQ-016 Eligible SHALL mean en=1 and ch_mask!=0.
REQ-017 in_ready SHALL be 1 when eligible and either state=IDLE, or state=HOLD with ch_ready[sel]=1; otherwise 0.
REQ-018 Accept SHALL mean in_valid & in_ready; transfer SHALL mean state=HOLD & ch_ready[sel].
REQ-019 On accept, the block SHALL register in_data into out_data and set sel to the first i in ptr, ptr+1, ..., ptr+7 (mod 8) with ch_mask[i]=1.
REQ-020 On accept, the block SHALL set ptr to (new sel + 1) mod 8; 7 wraps to 0.
REQ-021 IDLE with accept SHALL go to HOLD; IDLE without accept SHALL stay IDLE.
REQ-022 HOLD with transfer and accept in the same cycle SHALL stay HOLD with the new word and sel (back-to-back, 1 word/cycle).
REQ-023 HOLD with transfer and no accept SHALL go to IDLE; HOLD without transfer SHALL stay HOLD with out_data and sel unchanged.
REQ-024 out_valid SHALL equal (1 << sel) in HOLD and 0 in IDLE; the word is registered, so accept-to-out_valid latency is 1 cycle.
REQ-025 ch_mask and en SHALL be sampled only at accept; changing either during HOLD SHALL NOT alter sel or drop the held word.
REQ-026 ch_ready bits other than ch_ready[sel] SHALL be ignored.
REQ-027 xfer_cnt SHALL increment by 1 on every transfer and wrap from 0xFFFF to 0x0000.
REQ-028 in_ready SHALL NOT depend combinationally on in_valid.
REQ-029 Mask all-zero or en=0 SHALL hold in_ready=0; a word already held SHALL still be delivered.

Reset
REQ-030 On rst=1 at a clock edge, all of the following SHALL hold the next cycle:
- state=IDLE, ptr=0, sel=0
- out_valid=0, out_data=0, xfer_cnt=0
REQ-031 rst SHALL take priority over accept and transfer in the same cycle.
REQ-032 rst asserted in HOLD SHALL discard the held word, with no transfer counted.
REQ-033 in_ready SHALL be 0 during the cycle rst=1.

Verification
REQ-034 Fill and drain, no gaps:
- Stimulus: after reset, mask=0xFF, en=1, ch_ready=0xFF, in_valid=1 continuously, data 0x10,0x11,...
- Response: sel cycles 0,1,...,7,0; out_valid 0x01,0x02,...,0x80,0x01; one word per cycle; xfer_cnt=8 after eight transfers.
REQ-035 Sparse mask:
- Stimulus: mask=0x24 (channels 2 and 5), three words A,B,C.
- Response: sel=2,5,2; out_valid=0x04,0x20,0x04; ptr=3 after C.
REQ-036 Backpressure:
- Stimulus: word 0xAB held on sel=3, ch_ready=0xF7 for 5 cycles, then 0x08.
- Response: out_valid=0x08 and out_data=0xAB stable for 5 cycles; in_ready=0 during the stall; transfer on cycle 6; xfer_cnt+1.
REQ-037 Mask change and disable during HOLD:
- Stimulus: word held on sel=1, then mask set to 0x00 and en=0.
- Response: word still delivered on channel 1; afterwards state=IDLE and in_ready=0 while in_valid=1.
REQ-038 Reset mid-operation:
- Stimulus: rst=1 in HOLD with ch_ready[sel]=1 and in_valid=1.
- Response: next cycle out_valid=0, xfer_cnt=0, ptr=0; first post-reset word goes to the lowest set mask bit.
REQ-039 Counter wrap:
- Stimulus: xfer_cnt forced to 0xFFFF, then one transfer.
- Response: xfer_cnt=0x0000.
